// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
//   hz_state_t    : controller state (RUN, LU_STALL)
//   DEF_*         : default parameter values for the controller and its interface
//   lat_w()       : width of the load-latency down-counter for a given LOAD_LAT
package hazard_ctrl_unit_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hz_state_t;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int DEF_LOAD_LAT   = 1;
  localparam int DEF_CNT_W      = 32;

  // Enough bits to hold LOAD_LAT-1; at least one bit so the counter always exists.
  function automatic int lat_w(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Decode-side hazard information in, pipeline enables/flushes and counters out.
//   master : the pipeline (drives register indices, load/branch/busy status, cnt_clr)
//   slave  : the hazard controller (drives enables, flushes, loadUse, counters)
interface hazard_ctrl_unit_if #(
  parameter int REG_ADDR_W = hazard_ctrl_unit_pkg::DEF_REG_ADDR_W,
  parameter int CNT_W      = hazard_ctrl_unit_pkg::DEF_CNT_W
);
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs1_used;
  logic                  rs2_used;
  logic [REG_ADDR_W-1:0] de_ex_regRd;
  logic                  de_ex_memRead;
  logic                  branch_taken;
  logic                  mem_busy;
  logic                  cnt_clr;
  logic                  PC_write;
  logic                  de_write;
  logic                  ex_mem_write;
  logic                  fd_flush;
  logic                  de_ex_flush;
  logic                  loadUse;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output rs1, rs2, rs1_used, rs2_used, de_ex_regRd, de_ex_memRead,
           branch_taken, mem_busy, cnt_clr,
    input  PC_write, de_write, ex_mem_write, fd_flush, de_ex_flush, loadUse,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1, rs2, rs1_used, rs2_used, de_ex_regRd, de_ex_memRead,
           branch_taken, mem_busy, cnt_clr,
    output PC_write, de_write, ex_mem_write, fd_flush, de_ex_flush, loadUse,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter used for performance statistics.
//   CLK, RST : clock, async active-high reset (clears count)
//   clr      : synchronous clear, wins over inc
//   inc      : count this cycle
//   count    : current value, sticks at all-ones
module sat_counter
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use / branch-flush / memory-busy hazard controller for the 5-stage pipeline.
//   CLK, RST : clock, async active-high reset
//   hz       : slave side of hazard_ctrl_unit_if
//              in : rs1/rs2 (+used), de_ex_regRd, de_ex_memRead, branch_taken,
//                   mem_busy, cnt_clr
//              out: PC_write, de_write, ex_mem_write, fd_flush, de_ex_flush,
//                   loadUse, stall_cnt, flush_cnt
// Enables and flushes are combinational from inputs and state. A load-use
// stall holds PC and IF/DE for LOAD_LAT non-busy cycles; the first of those is
// spent in RUN, the remaining LOAD_LAT-1 in LU_STALL counted down by lat_cnt.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int LOAD_LAT   = DEF_LOAD_LAT,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               CLK,
  input  logic               RST,
  hazard_ctrl_unit_if.slave  hz
);

  localparam int LAT_W    = lat_w(LOAD_LAT);
  localparam int LAT_INIT = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;

  hz_state_t             state;
  logic [LAT_W-1:0]      lat_cnt;
  logic [REG_ADDR_W-1:0] rd;
  logic                  hazard;

  logic pc_write, de_write, ex_mem_write, fd_flush, de_ex_flush, load_use;
  logic stall_inc;

  assign rd = hz.de_ex_regRd;

  // x0 never carries a hazard; unused source fields are don't-care.
  assign hazard = hz.de_ex_memRead && (rd != '0) &&
                  ((hz.rs1_used && (hz.rs1 == rd)) ||
                   (hz.rs2_used && (hz.rs2 == rd)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= RUN;
      lat_cnt <= '0;
    end else if (!hz.mem_busy) begin
      case (state)
        RUN: begin
          // A taken branch squashes the DE instruction, so its hazard is moot.
          if (!hz.branch_taken && hazard && (LOAD_LAT > 1)) begin
            state   <= LU_STALL;
            lat_cnt <= LAT_W'(LAT_INIT);
          end
        end
        LU_STALL: begin
          if (lat_cnt == '0) state <= RUN;
          else               lat_cnt <= lat_cnt - LAT_W'(1);
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    de_write     = 1'b1;
    ex_mem_write = 1'b1;
    fd_flush     = 1'b0;
    de_ex_flush  = 1'b0;
    load_use     = 1'b0;
    if (RST) begin
      pc_write     = 1'b0;
      de_write     = 1'b0;
      ex_mem_write = 1'b0;
    end else if (hz.mem_busy) begin
      // Full freeze; loadUse still reports a stall in progress.
      pc_write     = 1'b0;
      de_write     = 1'b0;
      ex_mem_write = 1'b0;
      load_use     = (state == LU_STALL);
    end else if (state == LU_STALL) begin
      pc_write    = 1'b0;
      de_write    = 1'b0;
      de_ex_flush = 1'b1;
      load_use    = 1'b1;
    end else if (hz.branch_taken) begin
      fd_flush    = 1'b1;
      de_ex_flush = 1'b1;
    end else if (hazard) begin
      pc_write    = 1'b0;
      de_write    = 1'b0;
      de_ex_flush = 1'b1;
      load_use    = 1'b1;
    end
  end

  assign hz.PC_write     = pc_write;
  assign hz.de_write     = de_write;
  assign hz.ex_mem_write = ex_mem_write;
  assign hz.fd_flush     = fd_flush;
  assign hz.de_ex_flush  = de_ex_flush;
  assign hz.loadUse      = load_use;

  assign stall_inc = !pc_write;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (hz.cnt_clr),
    .inc   (stall_inc),
    .count (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (hz.cnt_clr),
    .inc   (fd_flush),
    .count (hz.flush_cnt)
  );

endmodule
